// File: rtl/uart_imem_loader.sv
// Assembles UART bytes (LSB first) into 32-bit words and writes them to sequential
// instruction-memory addresses until a terminator word arrives or memory fills up.
module uart_imem_loader #(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [31:0] TERMINATOR     = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_valid,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_break,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [31:0]       imem_wr_data,
    output logic              write_done,
    output logic              overflow,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned     IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        S_COLLECT,
        S_DONE
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [1:0]          r_bidx,    w_bidx_nxt;
    logic [23:0]         r_word_lo, w_word_lo_nxt;
    logic [IDLE_W-1:0]   r_idle,    w_idle_nxt;
    logic                r_wr_en,   w_wr_en_nxt;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
    logic [31:0]         r_wr_data, w_wr_data_nxt;
    logic                r_done,    w_done_nxt;
    logic                r_ovf,     w_ovf_nxt;
    logic [ADDR_W:0]     r_count,   w_count_nxt;
    logic [31:0]         w_word;

    // The completed word includes the byte arriving this cycle, so no extra buffering stage.
    assign w_word = {uart_rx_data, r_word_lo};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt   = r_state;
        w_bidx_nxt    = r_bidx;
        w_word_lo_nxt = r_word_lo;
        w_idle_nxt    = r_idle;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_done_nxt    = r_done;
        w_ovf_nxt     = r_ovf;
        w_count_nxt   = r_count;

        case (r_state)
            S_COLLECT: begin
                if (uart_rx_break) begin
                    // Break outranks a coincident byte: the partial word and that byte are dropped.
                    w_bidx_nxt = 2'd0;
                    w_idle_nxt = '0;
                end else if (uart_rx_valid) begin
                    w_idle_nxt = '0;
                    w_bidx_nxt = r_bidx + 2'd1;
                    case (r_bidx)
                        2'd0:    w_word_lo_nxt[7:0]   = uart_rx_data;
                        2'd1:    w_word_lo_nxt[15:8]  = uart_rx_data;
                        2'd2:    w_word_lo_nxt[23:16] = uart_rx_data;
                        default: begin
                            if (w_word == TERMINATOR) begin
                                w_done_nxt  = 1'b1;
                                w_state_nxt = S_DONE;
                            end else if (r_count < DEPTH) begin
                                w_wr_en_nxt   = 1'b1;
                                w_wr_addr_nxt = r_count[ADDR_W-1:0];
                                w_wr_data_nxt = w_word;
                                w_count_nxt   = r_count + 1'b1;
                            end else begin
                                w_ovf_nxt   = 1'b1;
                                w_done_nxt  = 1'b1;
                                w_state_nxt = S_DONE;
                            end
                        end
                    endcase
                end else if (r_bidx != 2'd0) begin
                    if (r_idle == IDLE_LAST) begin
                        w_bidx_nxt = 2'd0;
                        w_idle_nxt = '0;
                    end else begin
                        w_idle_nxt = r_idle + 1'b1;
                    end
                end else begin
                    w_idle_nxt = '0;
                end
            end
            default: begin
                // DONE is terminal until reset; inputs are ignored.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state   <= S_COLLECT;
            r_bidx    <= 2'd0;
            r_word_lo <= '0;
            r_idle    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bidx    <= w_bidx_nxt;
            r_word_lo <= w_word_lo_nxt;
            r_idle    <= w_idle_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_done    <= w_done_nxt;
            r_ovf     <= w_ovf_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign imem_wr_en   = r_wr_en;
    assign imem_wr_addr = r_wr_addr;
    assign imem_wr_data = r_wr_data;
    assign write_done   = r_done;
    assign overflow     = r_ovf;
    assign words_loaded = r_count;

endmodule
